regb_load_arbiter: RTL and testbench
====================================

Name: regb_load_arbiter

Overview:
- Shares the single load port of the Register B pipeline (load_b / data_in_b) among NUM_REQ requesters.
- Uses round-robin arbitration with an optional bounded burst lock per requester.
- Tracks each accepted load through the fixed 2-cycle Register B pipeline and emits a valid/owner tag aligned with data_out_b1.
- Sits between the requester front-ends and Register B, driving Register B's load inputs directly.

Parameters:
- DATA_WIDTH, 32, width of each requester data word and of data_in_b.
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive grants to one locked requester (1..15).
- ID_W, 2, width of the owner ID (must satisfy 2**ID_W >= NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- req  in  NUM_REQ  per-requester load request; held until ack.
- lock  in  NUM_REQ  per-requester burst-lock request; qualified by the matching req bit.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot, one-cycle pulse; requester i's load was issued this cycle.
- load_b  out  1  to Register B load_b (registered).
- data_in_b  out  DATA_WIDTH  to Register B data_in_b (registered).
- out_valid  out  1  data_out_b1 of Register B holds a newly loaded word this cycle.
- out_id  out  ID_W  owner index of the word flagged by out_valid.
- locked  out  1  FSM is in the LOCKED state.

Behaviour:
- Reset values: ack=0, load_b=0, data_in_b=0, out_valid=0, out_id=0, locked=0. RR pointer=0, burst count=0, tag pipeline cleared, FSM=ARB.
- Reset during a pending request: the request is dropped without ack. The requester keeps req asserted and is re-arbitrated after reset releases.
- Arbitration is evaluated at every rising edge from the sampled req. At most one winner per edge.
- Issuing a load: the winner w gets, in the following cycle, load_b=1, data_in_b=req_data[w], ack[w]=1. With no winner: load_b=0, ack=0, data_in_b holds its last value.
- Sustained load rate: one load per cycle when requests are continuous.
- Requester rule: req and req_data stay stable until ack. If req is still 1 in the ack cycle, it is treated as a new request at the next edge.
- ARB state: priority starts at the RR pointer p and runs p, p+1, ..., wrapping modulo NUM_REQ. After a grant, p = (w+1) mod NUM_REQ.
  - If lock[w]=1 and MAX_BURST>1: go to LOCKED with burst count=1.
- LOCKED state (owner L): if req[L]=1, L wins unconditionally and the burst count increments.
  - Exit to ARB when any of these holds:
    - req[L]=0: no grant to L this edge; normal RR arbitration runs in the same edge.
    - lock[L]=0 at a grant: this grant is the last of the burst.
    - burst count reaches MAX_BURST: this grant is the last; p = (L+1) mod NUM_REQ.
  - In LOCKED, p is not updated until exit.
- Register B timing: a word issued with load_b=1 in cycle c appears on data_out_b1 in cycle c+2.
- Tag pipeline: stage0 = {load_b, id}, shifted each cycle, unconditionally. out_valid/out_id are stage 2, so out_valid is asserted exactly 2 cycles after load_b, with the same id.
- Back-to-back loads produce back-to-back out_valid pulses.
- Simultaneous requests in ARB: the lowest offset from p wins; the others wait.
- No starvation: in the worst case, any held req is acked within (NUM_REQ-1)*MAX_BURST+1 grants.
- Stray inputs: lock without req is ignored. req bits at indices >= NUM_REQ do not exist (ports sized by NUM_REQ).

Test Plan:
- Reset then single request: req=3'b010, req_data[1]=32'hA5A5_0001 -> ack=3'b010 and load_b=1 one cycle after the sampling edge, data_in_b=32'hA5A5_0001. Two cycles later: out_valid=1, out_id=1, data_out_b1=32'hA5A5_0001.
- All three requesters hold req=3'b111, no lock, from reset -> acks in order 0,1,2,0,1,2 on consecutive cycles. out_id follows the same sequence delayed by 2 cycles.
- Requester 2 locked (lock=3'b100), req=3'b111, MAX_BURST=4 -> four consecutive acks to 2, locked=1 during the burst. Then ack to 0 and 1 before 2 is served again.
- Locked owner drops req after 2 grants -> FSM returns to ARB, locked=0. In the same edge, the next requester after the owner is granted, with no idle load cycle.
- Assert reset for 1 cycle while req=3'b011 and two loads are in flight in the tag pipeline -> out_valid=0 and load_b=0 on the next cycle, RR pointer=0. Requester 0 is acked first after release.
- Idle gaps: req pulses separated by 3 idle cycles -> load_b=0 and out_valid=0 in the gaps, data_in_b unchanged from the last load.

Source files
------------

// File: rtl/regb_load_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing the Register B load port.
// Tracks each issued load through the 2-cycle Register B pipeline to tag data_out_b1.
module regb_load_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          load_b,
    output logic [DATA_WIDTH-1:0]         data_in_b,
    output logic                          out_valid,
    output logic [ID_W-1:0]               out_id,
    output logic                          locked
);

    // state  | meaning
    // ARB    | round-robin arbitration from ptr
    // LOCKED | owner holds the port for up to MAX_BURST consecutive grants
    typedef enum logic {ARB, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt;
    logic [ID_W-1:0] owner, owner_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            grant;
    logic [ID_W-1:0] win;
    logic            rr_found;
    logic [ID_W-1:0] rr_win;
    logic [ID_W-1:0] id_q;
    logic            vld1, vld2;
    logic [ID_W-1:0] id1, id2;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + ID_W'(1);
    endfunction

    // Scan offsets from highest to lowest so the lowest offset from ptr wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                rr_found = 1'b1;
                rr_win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        win       = '0;
        if (state == LOCKED && req[owner]) begin
            grant   = 1'b1;
            win     = owner;
            cnt_nxt = cnt + 4'd1;
            if (!lock[owner] || cnt_nxt >= 4'(MAX_BURST)) begin
                state_nxt = ARB;
                ptr_nxt   = wrap_inc(owner);
                cnt_nxt   = '0;
            end
        end else begin
            // A locked owner that dropped req falls back to RR in the same edge.
            state_nxt = ARB;
            cnt_nxt   = '0;
            if (rr_found) begin
                grant   = 1'b1;
                win     = rr_win;
                ptr_nxt = wrap_inc(rr_win);
                if (lock[rr_win] && MAX_BURST > 1) begin
                    state_nxt = LOCKED;
                    owner_nxt = rr_win;
                    cnt_nxt   = 4'd1;
                end
            end
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack       <= '0;
            load_b    <= 1'b0;
            data_in_b <= '0;
            id_q      <= '0;
            vld1      <= 1'b0;
            id1       <= '0;
            vld2      <= 1'b0;
            id2       <= '0;
        end else begin
            ack    <= grant ? (NUM_REQ'(1) << win) : '0;
            load_b <= grant;
            if (grant) begin
                data_in_b <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                id_q      <= win;
            end
            vld1 <= load_b;
            id1  <= id_q;
            vld2 <= vld1;
            id2  <= id1;
        end
    end

    assign out_valid = vld2;
    assign out_id    = id2;

endmodule

// File: tb/tb_regb_load_arbiter.sv
// Directed and randomized bench for regb_load_arbiter against a behavioural grant model.
module tb_regb_load_arbiter;
    localparam int DW = 32;
    localparam int N  = 3;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            load_b;
    logic [DW-1:0]   data_in_b;
    logic            out_valid;
    logic [IW-1:0]   out_id;
    logic            locked;

    int total = 0;
    int bad   = 0;

    // Reference model: burst owner and grants left in the burst, rotating start point.
    bit            m_in_burst;
    int            m_owner, m_left, m_start;
    logic [N-1:0]  e_ack;
    logic          e_load;
    logic [DW-1:0] e_data;
    int            e_id;
    bit            tag_v[$];
    int            tag_i[$];

    regb_load_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB), .ID_W(IW)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .req_data(req_data),
        .ack(ack), .load_b(load_b), .data_in_b(data_in_b), .out_valid(out_valid),
        .out_id(out_id), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int w;
        if (reset) begin
            m_in_burst = 0; m_owner = 0; m_left = 0; m_start = 0;
            e_ack = '0; e_load = 0; e_data = '0; e_id = 0;
            tag_v = '{0, 0}; tag_i = '{0, 0};
            return;
        end
        tag_v.push_back(e_load); tag_i.push_back(e_id);
        void'(tag_v.pop_front()); void'(tag_i.pop_front());
        w = -1;
        if (m_in_burst && req[m_owner]) begin
            w = m_owner;
            m_left--;
            if (!lock[w] || m_left == 0) begin
                m_in_burst = 0;
                m_start = (w + 1) % N;
            end
        end else begin
            m_in_burst = 0;
            for (int k = 0; k < N && w < 0; k++)
                if (req[(m_start + k) % N]) w = (m_start + k) % N;
            if (w >= 0) begin
                m_start = (w + 1) % N;
                if (lock[w] && MB > 1) begin
                    m_in_burst = 1; m_owner = w; m_left = MB - 1;
                end
            end
        end
        e_ack  = (w >= 0) ? (N'(1) << w) : '0;
        e_load = (w >= 0);
        if (w >= 0) begin
            e_data = req_data[w*DW +: DW];
            e_id   = w;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ack", 64'(ack), 64'(e_ack));
        chk("load_b", 64'(load_b), 64'(e_load));
        chk("data_in_b", 64'(data_in_b), 64'(e_data));
        chk("out_valid", 64'(out_valid), 64'(tag_v[0]));
        chk("locked", 64'(locked), 64'(m_in_burst));
        if (tag_v[0]) chk("out_id", 64'(out_id), 64'(tag_i[0]));
    endtask

    initial begin
        tag_v = '{0, 0}; tag_i = '{0, 0};
        reset = 1; req = '0; lock = '0; req_data = '0;
        step(); step();
        chk("rst_out_id", 64'(out_id), 64'd0);
        reset = 0;

        // Single request from requester 1
        req = 3'b010; req_data[1*DW +: DW] = 32'hA5A5_0001;
        step();
        chk("single_ack", 64'(ack), 64'h2);
        chk("single_data", 64'(data_in_b), 64'hA5A5_0001);
        req = '0;
        step(); step();
        chk("single_ovalid", 64'(out_valid), 64'h1);
        chk("single_oid", 64'(out_id), 64'h1);

        // All three held, no lock
        req = 3'b111;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom();
        repeat (8) step();

        // Requester 2 locked
        lock = 3'b100;
        repeat (12) step();

        // Locked owner drops req after two grants
        req = 3'b001; lock = 3'b001;
        step(); step();
        chk("drop_locked", 64'(locked), 64'h1);
        req = 3'b110;
        step();
        chk("drop_unlock", 64'(locked), 64'h0);
        chk("drop_ack", 64'(ack), 64'h2);
        step();
        lock = '0; req = '0;
        step();

        // Reset with loads in flight
        req = 3'b011;
        step(); step();
        reset = 1;
        step();
        chk("rst_load", 64'(load_b), 64'h0);
        chk("rst_ovalid", 64'(out_valid), 64'h0);
        reset = 0;
        step();
        chk("rst_first", 64'(ack), 64'h1);
        step(); step();
        req = '0;
        step();

        // Idle gaps
        for (int g = 0; g < 3; g++) begin
            req = 3'b001; req_data[0 +: DW] = $urandom();
            step();
            req = '0;
            repeat (3) step();
        end

        // Randomized requesters honouring the hold-until-ack rule
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) req_data[i*DW +: DW] = $urandom();
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = $urandom();
                end
                lock[i] = ($urandom_range(0, 9) < 4);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
